writeback_stage: RTL and testbench

//  Final pipeline stage. Accepts retiring instructions from MEM, waits for the data-memory load

---
 rtl/writeback_stage_pkg.sv | 36 +++
 rtl/writeback_stage_load_aligner.sv | 45 ++++
 rtl/writeback_stage.sv | 162 ++++++++++++++++
 tb/tb_writeback_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_stage_pkg.sv
// writeback_stage_pkg
//   Shared definitions for the writeback stage: default widths, the reset value
//   of the register-file data bus, result-source encodings, load funct3 codes
//   and the FSM state type.
package writeback_stage_pkg;

  localparam int DATA_SIZE       = 32;
  localparam int REG_ADDR_SIZE   = 5;
  localparam int RETIRE_CNT_SIZE = 32;

  // Every bit of writeDate takes this value after reset.
  localparam logic DATA_BUS_RESET_BIT = 1'b0;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'b00,
    SRC_LOAD = 2'b01,
    SRC_PC4  = 2'b10,
    SRC_RSVD = 2'b11
  } wb_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_WAIT_LOAD = 1'b1
  } wb_state_e;

  function automatic logic is_load(input logic [1:0] src);
    return src == SRC_LOAD;
  endfunction

endpackage

// File: rtl/writeback_stage_load_aligner.sv
// writeback_stage_load_aligner
//   Combinational load extraction: picks the byte or halfword addressed by
//   byte_off out of an aligned 32-bit word and sign/zero-extends it.
//   LW and any undefined funct3 pass the word through unmodified.
// Ports
//   word      in   DATA_W  raw aligned word from data memory
//   funct3    in   3       load type
//   byte_off  in   2       load address[1:0] (bit 0 ignored for halfwords)
//   result    out  DATA_W  extended load value
module writeback_stage_load_aligner
  import writeback_stage_pkg::*;
#(
  parameter int DATA_W = DATA_SIZE
) (
  input  logic [DATA_W-1:0] word,
  input  logic [2:0]        funct3,
  input  logic [1:0]        byte_off,
  output logic [DATA_W-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (byte_off)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase

    half_sel = byte_off[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_LB:   result = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      F3_LH:   result = {{(DATA_W-16){half_sel[15]}}, half_sel};
      F3_LBU:  result = {{(DATA_W-8){1'b0}}, byte_sel};
      F3_LHU:  result = {{(DATA_W-16){1'b0}}, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage
//   Final pipeline stage. Accepts retiring instructions from MEM, waits for the
//   data-memory load response where needed, extends the load, selects the
//   result (ALU / load / PC+4) and drives the register-file write port with a
//   one-cycle pulse per writing instruction. Counts retired instructions.
//
//   Optional feature macro: WB_FORWARD_EN adds fwdValid/fwdAddr/fwdData, which
//   present the value being committed combinationally, one cycle ahead of
//   writeEnable, for EX bypass.
//
// Ports
//   clk, resetN                  clock / asynchronous active-low reset
//   inValid, inReady             MEM handshake (inReady low while waiting on a load)
//   inRegWrite, inRd, inSrc      writeback control
//   inAluResult, inPcPlus4       result candidates
//   inFunct3, inByteOff          load type and address[1:0]
//   memRspValid, memRspData      data-memory load response
//   writeEnable/writeAddr/writeDate  registered register-file write port
//   retired                      retired-instruction count (wraps)
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | ready; accepts and commits non-loads and same-cycle loads
// WAIT_LOAD | load accepted, holding its fields until memRspValid
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int DATA_W = DATA_SIZE,
  parameter int ADDR_W = REG_ADDR_SIZE,
  parameter int CNT_W  = RETIRE_CNT_SIZE
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              inValid,
  output logic              inReady,
  input  logic              inRegWrite,
  input  logic [ADDR_W-1:0] inRd,
  input  logic [1:0]        inSrc,
  input  logic [DATA_W-1:0] inAluResult,
  input  logic [DATA_W-1:0] inPcPlus4,
  input  logic [2:0]        inFunct3,
  input  logic [1:0]        inByteOff,
  input  logic              memRspValid,
  input  logic [DATA_W-1:0] memRspData,
  output logic              writeEnable,
  output logic [ADDR_W-1:0] writeAddr,
  output logic [DATA_W-1:0] writeDate,
  output logic [CNT_W-1:0]  retired
`ifdef WB_FORWARD_EN
  ,
  output logic              fwdValid,
  output logic [ADDR_W-1:0] fwdAddr,
  output logic [DATA_W-1:0] fwdData
`endif
);

  wb_state_e state;

  logic              cap_reg_write;
  logic [ADDR_W-1:0] cap_rd;
  logic [1:0]        cap_src;
  logic [2:0]        cap_funct3;
  logic [1:0]        cap_byte_off;

  logic              in_idle;
  logic              accept;
  logic              sel_reg_write;
  logic [ADDR_W-1:0] sel_rd;
  logic [1:0]        sel_src;
  logic [2:0]        sel_funct3;
  logic [1:0]        sel_byte_off;
  logic              commit;
  logic              commit_we;
  logic [DATA_W-1:0] load_value;
  logic [DATA_W-1:0] commit_data;

  // In IDLE the committing instruction is the one on the input bus; in
  // WAIT_LOAD it is the captured one.
  always_comb begin
    in_idle       = (state == ST_IDLE);
    accept        = inValid & in_idle;
    sel_reg_write = in_idle ? inRegWrite : cap_reg_write;
    sel_rd        = in_idle ? inRd       : cap_rd;
    sel_src       = in_idle ? inSrc      : cap_src;
    sel_funct3    = in_idle ? inFunct3   : cap_funct3;
    sel_byte_off  = in_idle ? inByteOff  : cap_byte_off;

    // memRspValid only matters when a load is being accepted or awaited.
    commit    = in_idle ? (accept & (!is_load(inSrc) | memRspValid)) : memRspValid;
    commit_we = commit & sel_reg_write & (sel_rd != '0);

    case (sel_src)
      SRC_LOAD: commit_data = load_value;
      SRC_PC4:  commit_data = inPcPlus4;
      default:  commit_data = inAluResult;
    endcase
  end

  assign inReady = in_idle;

  writeback_stage_load_aligner #(
    .DATA_W (DATA_W)
  ) u_load_aligner (
    .word     (memRspData),
    .funct3   (sel_funct3),
    .byte_off (sel_byte_off),
    .result   (load_value)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state         <= ST_IDLE;
      writeEnable   <= 1'b0;
      writeAddr     <= '0;
      writeDate     <= {DATA_W{DATA_BUS_RESET_BIT}};
      retired       <= '0;
      cap_reg_write <= 1'b0;
      cap_rd        <= '0;
      cap_src       <= '0;
      cap_funct3    <= '0;
      cap_byte_off  <= '0;
    end else begin
      writeEnable <= commit_we;
      if (commit_we) begin
        writeAddr <= sel_rd;
        writeDate <= commit_data;
      end
      // Instructions that do not write (rd==x0 or no regWrite) still retire.
      if (commit) begin
        retired <= retired + CNT_W'(1);
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            cap_reg_write <= inRegWrite;
            cap_rd        <= inRd;
            cap_src       <= inSrc;
            cap_funct3    <= inFunct3;
            cap_byte_off  <= inByteOff;
            if (is_load(inSrc) && !memRspValid) begin
              state <= ST_WAIT_LOAD;
            end
          end
        end
        ST_WAIT_LOAD: begin
          if (memRspValid) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef WB_FORWARD_EN
  assign fwdValid = commit_we;
  assign fwdAddr  = sel_rd;
  assign fwdData  = commit_data;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;
  import writeback_stage_pkg::*;

  logic        clk;
  logic        resetN;
  logic        inValid;
  logic        inReady;
  logic        inRegWrite;
  logic [4:0]  inRd;
  logic [1:0]  inSrc;
  logic [31:0] inAluResult;
  logic [31:0] inPcPlus4;
  logic [2:0]  inFunct3;
  logic [1:0]  inByteOff;
  logic        memRspValid;
  logic [31:0] memRspData;
  logic        writeEnable;
  logic [4:0]  writeAddr;
  logic [31:0] writeDate;
  logic [31:0] retired;

  // Second instance with a 2-bit counter so counter wrap is reachable.
  logic        s_inReady;
  logic        s_writeEnable;
  logic [4:0]  s_writeAddr;
  logic [31:0] s_writeDate;
  logic [1:0]  s_retired;

`ifdef WB_FORWARD_EN
  logic        fwdValid, s_fwdValid;
  logic [4:0]  fwdAddr, s_fwdAddr;
  logic [31:0] fwdData, s_fwdData;
`endif

  writeback_stage dut (
    .clk(clk), .resetN(resetN), .inValid(inValid), .inReady(inReady),
    .inRegWrite(inRegWrite), .inRd(inRd), .inSrc(inSrc), .inAluResult(inAluResult),
    .inPcPlus4(inPcPlus4), .inFunct3(inFunct3), .inByteOff(inByteOff),
    .memRspValid(memRspValid), .memRspData(memRspData),
    .writeEnable(writeEnable), .writeAddr(writeAddr), .writeDate(writeDate), .retired(retired)
`ifdef WB_FORWARD_EN
    , .fwdValid(fwdValid), .fwdAddr(fwdAddr), .fwdData(fwdData)
`endif
  );

  writeback_stage #(.CNT_W(2)) dut_s (
    .clk(clk), .resetN(resetN), .inValid(inValid), .inReady(s_inReady),
    .inRegWrite(inRegWrite), .inRd(inRd), .inSrc(inSrc), .inAluResult(inAluResult),
    .inPcPlus4(inPcPlus4), .inFunct3(inFunct3), .inByteOff(inByteOff),
    .memRspValid(memRspValid), .memRspData(memRspData),
    .writeEnable(s_writeEnable), .writeAddr(s_writeAddr), .writeDate(s_writeDate), .retired(s_retired)
`ifdef WB_FORWARD_EN
    , .fwdValid(s_fwdValid), .fwdAddr(s_fwdAddr), .fwdData(s_fwdData)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_retired = 0;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  // Scoreboard monitor: every write pulse must match the oldest expectation.
  always @(negedge clk) begin
    wr_t e;
    if (writeEnable) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got addr %0d data 0x%08h, required no write", writeAddr, writeDate);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(writeAddr), 64'(e.addr));
        check("wr_data", 64'(writeDate), 64'(e.data));
        check("small_wr", {s_writeEnable, s_writeAddr, s_writeDate}, {1'b1, e.addr, e.data});
      end
    end else if (s_writeEnable) begin
      n_checks++;
      $display("FAIL small_unexpected_write: got addr %0d, required no write", s_writeAddr);
    end
  end

  task automatic expect_wr(input logic rw, input logic [4:0] rd, input logic [31:0] data);
    wr_t e;
    if (rw && rd != 5'd0) begin
      e.addr = rd;
      e.data = data;
      exp_q.push_back(e);
    end
  endtask

  task automatic issue(input logic [1:0] src, input logic [4:0] rd, input logic rw,
                       input logic [31:0] alu, input logic [31:0] pc4,
                       input logic [2:0] f3, input logic [1:0] off,
                       input logic rsp, input logic [31:0] rsp_data);
    inValid = 1'b1; inSrc = src; inRd = rd; inRegWrite = rw;
    inAluResult = alu; inPcPlus4 = pc4; inFunct3 = f3; inByteOff = off;
    memRspValid = rsp; memRspData = rsp_data;
    @(posedge clk); #1;
    inValid = 1'b0; memRspValid = 1'b0;
  endtask

  task automatic do_load(input string name, input logic [2:0] f3, input logic [1:0] off,
                         input logic [31:0] word, input int waits, input logic [4:0] rd,
                         input logic [31:0] exp_data);
    expect_wr(1'b1, rd, exp_data);
    issue(SRC_LOAD, rd, 1'b1, 32'h0000_1000, 32'h0, f3, off, 1'b0, 32'h0);
    for (int i = 0; i < waits; i++) begin
      check({name, "_ready_wait"}, 64'(inReady), 64'd0);
      check({name, "_we_wait"}, 64'(writeEnable), 64'd0);
      @(posedge clk); #1;
    end
    memRspValid = 1'b1; memRspData = word;
    @(posedge clk); #1;
    memRspValid = 1'b0;
    exp_retired++;
    check({name, "_we"}, 64'(writeEnable), 64'd1);
    check({name, "_ready_after"}, 64'(inReady), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before timeout");
    $fatal(1);
  end

  initial begin
    resetN = 1'b0; inValid = 1'b0; inRegWrite = 1'b0; inRd = '0; inSrc = '0;
    inAluResult = '0; inPcPlus4 = '0; inFunct3 = '0; inByteOff = '0;
    memRspValid = 1'b0; memRspData = '0;
    #2;
    check("rst_ready", 64'(inReady), 64'd1);
    check("rst_we", 64'(writeEnable), 64'd0);
    check("rst_addr", 64'(writeAddr), 64'd0);
    check("rst_data", 64'(writeDate), 64'd0);
    check("rst_retired", 64'(retired), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    resetN = 1'b1;
    @(posedge clk); #1;

    // ALU op: write in the cycle after acceptance only.
    expect_wr(1'b1, 5'd5, 32'h1234_5678);
    issue(SRC_ALU, 5'd5, 1'b1, 32'h1234_5678, 32'h0, 3'd0, 2'd0, 1'b0, 32'h0);
    exp_retired++;
    check("alu_we_n1", 64'(writeEnable), 64'd1);
    check("alu_retired", 64'(retired), 64'(exp_retired));
    @(posedge clk); #1;
    check("alu_we_n2", 64'(writeEnable), 64'd0);

    // Loads with waits.
    do_load("lb",  F3_LB,  2'd3, 32'h80FF_0000, 2, 5'd6, 32'hFFFF_FF80);
    do_load("lbu", F3_LBU, 2'd3, 32'h80FF_0000, 2, 5'd7, 32'h0000_0080);
    do_load("lh",  F3_LH,  2'd2, 32'h8001_0000, 1, 5'd8, 32'hFFFF_8001);
    do_load("lhu", F3_LHU, 2'd3, 32'h8001_0000, 3, 5'd9, 32'h0000_8001);
    do_load("lb1", F3_LB,  2'd1, 32'h0000_7F00, 1, 5'd3, 32'h0000_007F);
    do_load("f3u", 3'b011, 2'd2, 32'hCAFE_F00D, 1, 5'd4, 32'hCAFE_F00D);
    @(posedge clk); #1;

    // LW with the response in the acceptance cycle: no wait state.
    expect_wr(1'b1, 5'd10, 32'h8001_0000);
    issue(SRC_LOAD, 5'd10, 1'b1, 32'h0, 32'h0, F3_LW, 2'd0, 1'b1, 32'h8001_0000);
    exp_retired++;
    check("lw_same_we", 64'(writeEnable), 64'd1);
    check("lw_same_ready", 64'(inReady), 64'd1);
    @(posedge clk); #1;

    // rd=x0: no write, still retires.
    issue(SRC_ALU, 5'd0, 1'b1, 32'hDEAD_BEEF, 32'h0, 3'd0, 2'd0, 1'b0, 32'h0);
    exp_retired++;
    check("x0_we", 64'(writeEnable), 64'd0);
    check("x0_retired", 64'(retired), 64'(exp_retired));

    // PC+4 and reserved source selection; regWrite=0 retires silently.
    expect_wr(1'b1, 5'd1, 32'h0000_0104);
    issue(SRC_PC4, 5'd1, 1'b1, 32'h0000_0999, 32'h0000_0104, 3'd0, 2'd0, 1'b0, 32'h0);
    exp_retired++;
    expect_wr(1'b1, 5'd2, 32'h5555_AAAA);
    issue(SRC_RSVD, 5'd2, 1'b1, 32'h5555_AAAA, 32'h0000_0108, 3'd0, 2'd0, 1'b0, 32'h0);
    exp_retired++;
    issue(SRC_ALU, 5'd7, 1'b0, 32'h1111_1111, 32'h0, 3'd0, 2'd0, 1'b0, 32'h0);
    exp_retired++;
    check("norw_we", 64'(writeEnable), 64'd0);

    // Stray response while idle is ignored.
    memRspValid = 1'b1; memRspData = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    memRspValid = 1'b0;
    check("stray_rsp_retired", 64'(retired), 64'(exp_retired));
    check("stray_rsp_ready", 64'(inReady), 64'd1);

    // Reset in WAIT_LOAD abandons the load.
    issue(SRC_LOAD, 5'd12, 1'b1, 32'h0, 32'h0, F3_LW, 2'd0, 1'b0, 32'h0);
    check("rstwait_ready_before", 64'(inReady), 64'd0);
    resetN = 1'b0;
    #2;
    exp_retired = 0;
    check("rstwait_retired", 64'(retired), 64'd0);
    check("rstwait_ready", 64'(inReady), 64'd1);
    @(posedge clk); #1;
    resetN = 1'b1;
    memRspValid = 1'b1; memRspData = 32'h1357_9BDF;
    @(posedge clk); @(posedge clk); #1;
    memRspValid = 1'b0;
    check("stale_we", 64'(writeEnable), 64'd0);
    check("stale_retired", 64'(retired), 64'd0);
    check("stale_ready", 64'(inReady), 64'd1);

    // Four back-to-back ALU ops; the 2-bit counter wraps 3 -> 0.
    for (int i = 0; i < 4; i++) begin
      inValid = 1'b1; inSrc = SRC_ALU; inRegWrite = 1'b1;
      inRd = 5'(20 + i); inAluResult = 32'hA000_0000 + 32'(i);
      expect_wr(1'b1, 5'(20 + i), 32'hA000_0000 + 32'(i));
      @(posedge clk); #1;
      exp_retired++;
      check("b2b_we", 64'(writeEnable), 64'd1);
      check("b2b_small_retired", 64'(s_retired), 64'(exp_retired % 4));
    end
    inValid = 1'b0;
    @(posedge clk); #1;
    check("b2b_we_end", 64'(writeEnable), 64'd0);
    check("b2b_retired", 64'(retired), 64'd4);

    @(posedge clk); #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
